// File: rtl/serial_pkg.sv
// Shared types and constants for the 4-bit serial transmitter.
package serial_pkg;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Width of the parallel word being serialized.
  localparam int DATA_W = 4;

  // Bit periods per frame: start + DATA_W data bits + stop.
  localparam int FRAME_BITS = 6;

endpackage

// File: rtl/serial_tx_4b_if.sv
// Parallel-side handshake and serial line of the 4-bit transmitter.
interface serial_tx_4b_if;
  import serial_pkg::*;

  logic              load;
  logic [DATA_W-1:0] I;
  logic              ready;
  logic              busy;
  logic              sout;
  logic              done;

  // Side that requests frames and watches the line.
  modport master (
    output load, I,
    input  ready, busy, sout, done
  );

  // The transmitter itself.
  modport slave (
    input  load, I,
    output ready, busy, sout, done
  );

endinterface

// File: rtl/bit_tick_gen.sv
// Bit-period counter: tick pulses on the last cycle of every bit period.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  // At least one bit so CLKS_PER_BIT=1 still has a legal counter.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: hold at zero while cleared, wrap on the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_4b.sv
// 4-bit serializer: start bit, four data bits LSB first, stop bit.
// All outputs come straight from flops, decoded from the next state so
// they line up with the state they describe.
module serial_tx_4b
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_tx_4b_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic              sout_q, sout_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              tick_clear;

  // The period counter sits at zero in IDLE so START begins on a fresh period.
  assign tick_clear = (state_q == IDLE);

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(tick_clear),
    .tick (tick)
  );

  // Next-state, shift register, bit index and registered-output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_d = bus.I;
          idx_d   = 2'd0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          idx_d   = 2'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == 2'd3) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shift_d[0];
      default: sout_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces an idle, high line at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= 2'd0;
      sout_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.sout  = sout_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: doc/serial_tx_4b.md
SERIAL_TX_4B -- requirements
Module: serial_tx_4b

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit period; legal range 1..256.
REQ-002 clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 load  input  1  request to transmit the word on I; sampled only on posedge clk.
REQ-005 I  input  4  parallel data word to serialize.
REQ-006 ready  output  1  high when a load will be accepted (IDLE state only).
REQ-007 busy  output  1  high while a frame is in progress (START, DATA or STOP).
REQ-008 sout  output  1  serial line; idles high.
REQ-009 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 The block shall implement a 4-state FSM: IDLE, START, DATA, STOP.
REQ-011 IDLE: sout=1, ready=1, busy=0; on posedge clk with load=1, capture I into a 4-bit shift register, clear the bit-period counter and the bit index, and go to START.
REQ-012 load=0 in IDLE shall leave all state unchanged; I is ignored except on the accepting edge.
REQ-013 START: sout=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-014 DATA: sout = shift register bit 0 (LSB first); after each CLKS_PER_BIT cycles, shift right by one and increment bit index; after the period of bit index 3, go to STOP.
REQ-015 STOP: sout=1 for exactly CLKS_PER_BIT cycles, then go to IDLE.
REQ-016 done shall be 1 for exactly the first cycle after the STOP->IDLE transition and 0 otherwise.
REQ-017 sout, ready, busy and done shall be registered outputs (no combinational path from load or I).
REQ-018 A frame occupies exactly 6*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
REQ-019 load asserted while busy=1 shall be ignored with no effect on the frame in progress or on the captured word.
REQ-020 Back-to-back: load held high continuously shall start the next frame on the edge that ends the first IDLE cycle (done=1 and ready=1 in that cycle), giving exactly one idle-high cycle between frames.
REQ-021 Changes on I after the accepting edge shall not affect the transmitted bits.
REQ-022 The bit-period counter shall be ceil(log2(CLKS_PER_BIT)) bits wide (minimum 1), count 0..CLKS_PER_BIT-1 and wrap to 0 on every bit boundary; CLKS_PER_BIT=1 shall give one cycle per bit.
REQ-023 The bit index shall be 2 bits wide; 3->STOP shall not wrap back into DATA.

Reset
REQ-024 While rst=1, regardless of clk: state=IDLE, sout=1, ready=1, busy=0, done=0, shift register=0, counters=0.
REQ-025 rst asserted mid-frame shall abort the frame immediately; sout returns high without waiting for a clock edge and done shall not pulse.
REQ-026 The first load accepted is the one sampled on the first posedge clk after rst deasserts.

Structure
REQ-027 A shared package serial_pkg shall hold the FSM state typedef (IDLE, START, DATA, STOP), the data width constant (4) and the frame bit count constant (6).
REQ-028 The bit-period counter shall be a single sub-module bit_tick_gen (parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick pulsing on the last cycle of each bit period).
REQ-029 Total RTL including bit_tick_gen shall be single-clock, with no latches and no gated clocks.

Verification
REQ-030 CLKS_PER_BIT=4, load=1 with I=4'b1010 in IDLE -> sout sequence per 4-cycle period: 0,0,1,0,1,1; done pulses once 24 cycles after the START cycle begins; ready=0 throughout.
REQ-031 CLKS_PER_BIT=1, load held high, I=4'b0001 then 4'b1111 -> sout: 0,1,0,0,0,1,1(idle),0,1,1,1,1,1; done high on both idle cycles.
REQ-032 Mid-frame load with I=4'b0110 during DATA of frame I=4'b1001 -> transmitted data bits remain 1,0,0,1; no second frame starts.
REQ-033 rst asserted asynchronously in DATA bit index 2 -> sout=1, busy=0, ready=1 before the next posedge; done stays 0; a subsequent load of 4'b0011 transmits a full correct frame.
REQ-034 I toggled every cycle after acceptance of 4'b1100 -> sout data bits 0,0,1,1.
REQ-035 Idle with load=0 for 100 cycles after reset -> sout=1, ready=1, busy=0, done=0 throughout.
